// File: rtl/us_timer_arb.sv
// Round-robin arbiter handing one shared microsecond timer to four requesters.
// A granted channel runs until its duration expires (Done pulse) or it drops Req.
module us_timer_arb #(
  parameter int T1USval = 49
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  Req,
  input  logic [63:0] Dur,
  output logic [3:0]  Gnt,
  output logic [3:0]  Done,
  output logic        Busy,
  output logic [15:0] Elapsed
);

  localparam int PW = (T1USval > 0) ? $clog2(T1USval + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(T1USval);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   durl_q, durl_d;
  logic [15:0]   elapsed_q, elapsed_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [3:0]    done_q, done_d;
  logic          busy_q, busy_d;

  logic [7:0]    dbl;
  logic [2:0]    rot_idx;
  logic [3:0]    rot;
  logic [1:0]    off;
  logic [1:0]    win;
  logic [15:0]   dur_w;
  logic [15:0]   el_inc;
  logic          wrap;

  // Winner search: rotate Req so bit 0 is channel Last+1, take lowest set bit.
  always_comb begin
    dbl     = {Req, Req};
    rot_idx = {1'b0, last_q} + 3'd1;
    rot     = dbl[rot_idx +: 4];
    if (rot[0]) begin
      off = 2'd0;
    end else if (rot[1]) begin
      off = 2'd1;
    end else if (rot[2]) begin
      off = 2'd2;
    end else begin
      off = 2'd3;
    end
    win   = last_q + 2'd1 + off;
    dur_w = Dur[{win, 4'b0000} +: 16];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    durl_d    = durl_q;
    elapsed_d = elapsed_q;
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    wrap      = (pre_q == PMAX);
    el_inc    = elapsed_q + 16'd1;
    unique case (state_q)
      IDLE: begin
        if (|Req) begin
          sel_d     = win;
          durl_d    = dur_w;
          pre_d     = '0;
          elapsed_d = '0;
          gnt_d     = 4'b0001 << win;
          if (dur_w == 16'd0) begin
            state_d = DONE;
            done_d  = 4'b0001 << win;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!Req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = sel_q;
        end else if (wrap) begin
          pre_d     = '0;
          elapsed_d = el_inc;
          if (el_inc == durl_q) begin
            state_d = DONE;
            gnt_d   = '0;
            done_d  = 4'b0001 << sel_q;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = sel_q;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; Last resets to 3 so channel 0 wins first.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      durl_q    <= '0;
      elapsed_q <= '0;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      durl_q    <= durl_d;
      elapsed_q <= elapsed_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign Gnt     = gnt_q;
  assign Done    = done_q;
  assign Busy    = busy_q;
  assign Elapsed = elapsed_q;

endmodule

// File: tb/tb_us_timer_arb.sv
// Bench for us_timer_arb: directed scenarios plus random transactions
// checked against a transaction-level round-robin / latency model.
module tb_us_timer_arb;

  localparam int TUS = 50;

  logic        CLK;
  logic        RSTn;
  logic [3:0]  Req;
  logic [63:0] Dur;
  logic [3:0]  Gnt;
  logic [3:0]  Done;
  logic        Busy;
  logic [15:0] Elapsed;

  int checks;
  int errors;
  int last_m;

  us_timer_arb #(.T1USval(TUS - 1)) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .Req(Req),
    .Dur(Dur),
    .Gnt(Gnt),
    .Done(Done),
    .Busy(Busy),
    .Elapsed(Elapsed)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int l);
    for (int k = 1; k <= 4; k++) begin
      if (m[(l + k) % 4]) return (l + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int w);
    logic [3:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Starts at an IDLE sample point; ends at the next IDLE sample point.
  // ab >= 0 drops the winner's Req after ab cycles of the grant.
  task automatic xact(input logic [3:0] m, input logic [63:0] d,
                      input int ab);
    int w;
    int dur;
    Req = m;
    Dur = d;
    w   = rr_pick(m, last_m);
    dur = int'(d[16*w +: 16]);
    tick();
    chk("gnt", Gnt, oh(w));
    chk("busy_run", Busy, 1);
    if (dur == 0) begin
      chk("done0", Done, oh(w));
      chk("el0", Elapsed, 0);
      tick();
      chk("done0_end", Done, 0);
      chk("busy0_end", Busy, 0);
      chk("gnt0_end", Gnt, 0);
    end else if (ab >= 0 && ab < dur * TUS) begin
      chk("done_run", Done, 0);
      repeat (ab) tick();
      Req[w] = 1'b0;
      tick();
      chk("abort_gnt", Gnt, 0);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      chk("abort_el", Elapsed, ab / TUS);
    end else begin
      chk("el_start", Elapsed, 0);
      repeat (dur * TUS - 1) tick();
      chk("done_early", Done, 0);
      chk("gnt_hold", Gnt, oh(w));
      tick();
      chk("done", Done, oh(w));
      chk("done_gnt", Gnt, 0);
      chk("done_el", Elapsed, dur);
      chk("done_busy", Busy, 1);
      tick();
      chk("done_end", Done, 0);
      chk("idle_busy", Busy, 0);
    end
    last_m = w;
  endtask

  initial begin
    logic [63:0] d;
    logic [3:0]  m;
    int          ab;
    checks = 0;
    errors = 0;
    last_m = 3;
    RSTn   = 1'b0;
    Req    = '0;
    Dur    = '0;
    repeat (3) tick();
    chk("rst_gnt", Gnt, 0);
    chk("rst_done", Done, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_el", Elapsed, 0);
    RSTn = 1'b1;
    tick();
    chk("idle_noreq", Busy, 0);

    // four requesters, Dur=1: served 0,1,2,3 with a 2-cycle gap
    for (int i = 0; i < 4; i++) xact(4'b1111, {4{16'd1}}, -1);

    xact(4'b0001, {48'd0, 16'd3}, -1);
    xact(4'b0100, 64'd0, -1);
    xact(4'b0010, {32'd0, 16'd10, 16'd0}, 120);

    // two requesters held continuously alternate
    for (int i = 0; i < 4; i++) xact(4'b0011, {4{16'd2}}, -1);

    // reset mid-RUN
    Req = 4'b0001;
    Dur = {48'd0, 16'd100};
    tick();
    chk("long_gnt", Gnt, 4'b0001);
    repeat (1999) tick();
    chk("long_el", Elapsed, 1999 / TUS);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_gnt", Gnt, 0);
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_el", Elapsed, 0);
    chk("mid_rst_done", Done, 0);
    tick();
    RSTn   = 1'b1;
    last_m = 3;
    tick();
    chk("regnt", Gnt, 4'b0001);
    Req = 4'b0000;
    tick();
    chk("regnt_abort", Busy, 0);
    chk("regnt_el", Elapsed, 0);
    last_m = 0;

    // random transactions
    for (int n = 0; n < 30; n++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < 4; c++) d[16*c +: 16] = 16'($urandom_range(0, 6));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : -1;
      xact(m, d, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/us_timer_arb.md
US_TIMER_ARB -- requirements
Module: us_timer_arb

Interface
REQ-001 Parameter: T1USval, default 49, CLK cycles per microsecond minus 1 (50 MHz -> 49).
REQ-002 CLK  input  1  system clock, rising-edge active.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 Req  input  4  per-channel timeout request, level, held high until Done or abort.
REQ-005 Dur  input  64  per-channel duration in us; channel i = Dur[16i+15:16i]; sampled only at grant.
REQ-006 Gnt  output  4  one-hot grant; channel i owns the shared us timer while Gnt[i]=1.
REQ-007 Done  output  4  one-cycle pulse on channel i when its duration expires.
REQ-008 Busy  output  1  high while state is not IDLE.
REQ-009 Elapsed  output  16  microseconds elapsed for the current or last grant.

Function
REQ-010 Block shall share one prescaler and one 16-bit us counter among 4 requesters, one grant at a time.
REQ-011 FSM states shall be IDLE, RUN, DONE; all outputs registered.
REQ-012 IDLE: if any Req bit is high, the block shall select a winner round-robin, searching from Last+1 mod 4 upward.
REQ-013 On the grant edge: Gnt = one-hot(winner), Sel = winner, DurL = Dur of winner, Pre = 0, Elapsed = 0; next state RUN, or DONE if DurL = 0.
REQ-014 RUN: Pre shall count 0..T1USval and wrap to 0; on the wrap edge, Elapsed shall increment by 1.
REQ-015 RUN: on the wrap edge where Elapsed+1 = DurL, next state shall be DONE, and Elapsed shall take the value DurL.
REQ-016 RUN latency: Done[Sel] shall be high in the cycle following exactly DurL*(T1USval+1) RUN cycles after the grant edge.
REQ-017 DONE: Done[Sel]=1 for exactly one cycle; Gnt=0; Last=Sel; Elapsed holds; next state IDLE.
REQ-018 Abort: if Req[Sel] is low while in RUN, next state shall be IDLE, Gnt=0, Last=Sel, and no Done is generated; Elapsed holds its value.
REQ-019 Abort on the same edge as the final wrap shall take priority: no Done is generated.
REQ-020 Dur and the Req bits of non-granted channels shall be ignored during RUN and DONE.
REQ-021 The minimum gap between consecutive grants shall be the single DONE cycle plus one IDLE cycle.
REQ-022 A requester that holds Req high after its own Done shall be re-granted only after other pending channels are served.
REQ-023 DurL = 65535 shall complete without counter wrap; Elapsed shall never exceed DurL.
REQ-024 Busy shall be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-025 Asserting RSTn low at any time, including mid-RUN, shall force: state IDLE, Gnt=0, Done=0, Busy=0, Elapsed=0, Pre=0, DurL=0, Sel=0, Last=3 (channel 0 has first priority).
REQ-026 After RSTn deasserts, the first grant shall occur no earlier than the first rising CLK edge.

Verification (T1USval=49)
REQ-027 Req=0001, Dur0=3 -> Gnt=0001 one edge later; Done[0] after 150 RUN cycles; Elapsed=3.
REQ-028 Req=1111, all Dur=1 -> grants in order 0,1,2,3; each Done 50 cycles after its grant; 2-cycle gap between grants.
REQ-029 Req=0100, Dur2=0 -> grant, then DONE next cycle, Done[2] pulse, Elapsed=0.
REQ-030 Req=0010, Dur1=10; drop Req[1] after 120 cycles -> IDLE, no Done, Elapsed=2.
REQ-031 Req=0001, Dur0=100; pulse RSTn low at cycle 2000 -> all outputs 0; re-grant of ch0 after release.
REQ-032 Req=0011 held continuously, Dur=2 -> alternating grants 0,1,0,1, none starved.
